// File: rtl/laplace_char_reader.sv
// laplace_char_reader: issues one index request to the Laplace LUT character
// source, captures the returned ASCII characters into a local buffer and exposes
// them through a registered read port.
//
// Optional feature macro: READER_TIMEOUT_EN. When it is defined, a watchdog
// aborts REQ/RECV after TIMEOUT idle cycles and sets error. When it is not
// defined, error is tied to 0.
//
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   start, index      - fetch request (sampled in IDLE) and the entry to fetch
//   busy, done        - high in REQ/RECV; one-cycle completion pulse
//   error, overflow   - sticky timeout flag / dropped-character flag
//   count             - number of characters stored
//   lut_req/lut_index - request and latched index to the source; lut_ack accepts it
//   char_valid/char_data/chars_remaining - character stream from the source
//   rd_addr, rd_data  - buffer read port with 1-cycle latency
module laplace_char_reader #(
  parameter int unsigned IDX_W   = 4,
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [IDX_W-1:0]         index,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     lut_req,
  output logic [IDX_W-1:0]         lut_index,
  input  logic                     lut_ack,
  input  logic                     char_valid,
  input  logic [7:0]               char_data,
  input  logic [7:0]               chars_remaining,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [7:0]               rd_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // Reject parameter sets the buffer and watchdog logic cannot support.
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_bad_params
    $error("laplace_char_reader: DEPTH must be a power of two >= 4 and TIMEOUT >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RECV,
    S_DONE
  } state_t;

  state_t     state;
  logic [7:0] mem [DEPTH];
  logic       room_c;
  logic       wr_en_c;

  assign room_c  = (count < CW'(DEPTH));
  assign wr_en_c = (state == S_RECV) && char_valid && room_c;

`ifdef READER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT);
  logic [TW-1:0] wdog;
  logic          error_r;
  logic          wdog_hit_c;

  // Hitting TIMEOUT-1 on this edge means TIMEOUT idle cycles once the edge completes.
  assign wdog_hit_c = (wdog == TW'(TIMEOUT - 1));
  assign error      = error_r;
`else
  assign error = 1'b0;
`endif

  // Character buffer: no reset, contents survive reset and completion.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[count[AW-1:0]] <= char_data;
    end
  end

  // Registered read port; same-address write in the same cycle returns old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= 8'h00;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      count     <= '0;
      lut_req   <= 1'b0;
      lut_index <= '0;
`ifdef READER_TIMEOUT_EN
      wdog      <= '0;
      error_r   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            lut_index <= index;
            count     <= '0;
            overflow  <= 1'b0;
            busy      <= 1'b1;
            lut_req   <= 1'b1;
            state     <= S_REQ;
`ifdef READER_TIMEOUT_EN
            wdog      <= '0;
            error_r   <= 1'b0;
`endif
          end
        end
        S_REQ: begin
          if (lut_ack) begin
            lut_req <= 1'b0;
            state   <= S_RECV;
`ifdef READER_TIMEOUT_EN
            wdog    <= '0;
          end else if (wdog_hit_c) begin
            lut_req <= 1'b0;
            busy    <= 1'b0;
            error_r <= 1'b1;
            state   <= S_IDLE;
          end else begin
            wdog    <= wdog + TW'(1);
`endif
          end
        end
        S_RECV: begin
          if (char_valid) begin
            if (room_c) begin
              count <= count + CW'(1);
            end else begin
              overflow <= 1'b1;
            end
            if (chars_remaining == 8'd0) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end
`ifdef READER_TIMEOUT_EN
            wdog <= '0;
          end else if (wdog_hit_c) begin
            busy    <= 1'b0;
            error_r <= 1'b1;
            state   <= S_IDLE;
          end else begin
            wdog <= wdog + TW'(1);
`endif
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_laplace_char_reader.sv
// Scoreboard bench for laplace_char_reader: stimulus queues expected completion
// records and read data; a negedge monitor pops and compares them when the DUT
// pulses done or a read result becomes due.
module tb_laplace_char_reader;

  localparam int unsigned IDX_W   = 4;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned AW      = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [IDX_W-1:0] index = '0;
  logic             busy, done, error, overflow;
  logic [AW:0]      count;
  logic             lut_req;
  logic [IDX_W-1:0] lut_index;
  logic             lut_ack = 1'b0;
  logic             char_valid = 1'b0;
  logic [7:0]       char_data = 8'h00;
  logic [7:0]       chars_remaining = 8'h00;
  logic [AW-1:0]    rd_addr = '0;
  logic [7:0]       rd_data;

  laplace_char_reader #(.IDX_W(IDX_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .index(index),
    .busy(busy), .done(done), .error(error), .overflow(overflow), .count(count),
    .lut_req(lut_req), .lut_index(lut_index), .lut_ack(lut_ack),
    .char_valid(char_valid), .char_data(char_data), .chars_remaining(chars_remaining),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int   cnt;
    logic ovf;
    logic err;
  } done_exp_t;

  done_exp_t  done_q[$];
  logic [7:0] rd_q[$];
  logic       rd_en = 1'b0;
  logic       rd_pend = 1'b0;
  done_exp_t  d;
  logic [7:0] e;

  always @(posedge clk) rd_pend <= rd_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs against the scoreboard queues.
  always @(negedge clk) begin
    if (rst_n && rd_pend) begin
      if (rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected: read result with empty queue at %0t", $time);
      end else begin
        e = rd_q.pop_front();
        check("rd_data", 32'(rd_data), 32'(e));
      end
    end
    if (done === 1'b1) begin
      if (done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL done_unexpected: done=1 with nothing expected at %0t", $time);
      end else begin
        d = done_q.pop_front();
        check("done_count", 32'(count), 32'(d.cnt));
        check("done_overflow", 32'(overflow), 32'(d.ovf));
        check("done_error", 32'(error), 32'(d.err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_done(input int c, input logic o);
    done_exp_t x;
    x.cnt = c; x.ovf = o; x.err = 1'b0;
    done_q.push_back(x);
  endtask

  task automatic do_start(input logic [IDX_W-1:0] idx);
    start = 1'b1; index = idx;
    tick();
    start = 1'b0;
  endtask

  task automatic ack();
    lut_ack = 1'b1;
    tick();
    lut_ack = 1'b0;
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] rem);
    char_valid = 1'b1; char_data = c; chars_remaining = rem;
    tick();
    char_valid = 1'b0;
  endtask

  task automatic read_chk(input string s);
    for (int i = 0; i < s.len(); i++) begin
      rd_addr = AW'(i);
      rd_en = 1'b1;
      rd_q.push_back(s[i]);
      tick();
    end
    rd_en = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    string s;
    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_lut_req", 32'(lut_req), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic fetch of "1/s^2" with gaps, plus a start pulse during RECV
    do_start(4'd3);
    check("basic_busy", 32'(busy), 32'd1);
    check("basic_lut_req", 32'(lut_req), 32'd1);
    check("basic_lut_index", 32'(lut_index), 32'd3);
    tick();
    ack();
    check("basic_req_drop", 32'(lut_req), 32'd0);
    s = "1/s^2";
    expect_done(5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      send(s[i], 8'(4 - i));
      if (i == 1) begin
        start = 1'b1; index = 4'd5;
        tick();
        start = 1'b0;
        check("lock_lut_index", 32'(lut_index), 32'd3);
        check("lock_lut_req", 32'(lut_req), 32'd0);
        check("lock_busy", 32'(busy), 32'd1);
      end else if (i < 4) begin
        tick();
      end
    end
    check("basic_busy_low", 32'(busy), 32'd0);
    check("basic_count", 32'(count), 32'd5);
    tick();
    read_chk(s);

    // Single character; a char in REQ must be ignored; start after done accepted
    do_start(4'd9);
    check("single_lut_index", 32'(lut_index), 32'd9);
    check("single_count_clr", 32'(count), 32'd0);
    send("Q", 8'd0);
    ack();
    expect_done(1, 1'b0);
    send("Z", 8'd0);
    check("single_busy_low", 32'(busy), 32'd0);
    tick();
    read_chk("Z");

    // Overflow: 10 characters into an 8-deep buffer
    do_start(4'd1);
    ack();
    s = "ABCDEFGHIJ";
    expect_done(8, 1'b1);
    for (int i = 0; i < 10; i++) send(s[i], 8'(9 - i));
    check("ovf_flag", 32'(overflow), 32'd1);
    tick();
    read_chk("ABCDEFGH");

    // Reset mid-RECV after 2 of 5 characters
    do_start(4'd2);
    check("ovf_cleared", 32'(overflow), 32'd0);
    ack();
    send("x", 8'd4);
    send("y", 8'd3);
    rst_n = 1'b0;
    #2;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_lut_req", 32'(lut_req), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_error", 32'(error), 32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    tick();
    read_chk("xy");
    do_start(4'd6);
    check("post_rst_lut_index", 32'(lut_index), 32'd6);
    ack();
    expect_done(2, 1'b0);
    send("o", 8'd1);
    tick();
    send("k", 8'd0);
    tick();
    read_chk("ok");

`ifdef READER_TIMEOUT_EN
    // Watchdog: no lut_ack
    do_start(4'd4);
    repeat (7) tick();
    check("to_req_held", 32'(lut_req), 32'd1);
    check("to_err_low", 32'(error), 32'd0);
    tick();
    check("to_req_drop", 32'(lut_req), 32'd0);
    check("to_error", 32'(error), 32'd1);
    check("to_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    do_start(4'd4);
    check("to_err_clr", 32'(error), 32'd0);
    ack();
    expect_done(1, 1'b0);
    send("T", 8'd0);
    tick();
`endif

    repeat (3) tick();
    checks++;
    if (done_q.size() != 0) begin
      errors++;
      $display("FAIL done_missing: %0d completions never seen", done_q.size());
    end
    checks++;
    if (rd_q.size() != 0) begin
      errors++;
      $display("FAIL rd_missing: %0d reads never checked", rd_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/laplace_char_reader.md
# laplace_char_reader

Host-side reader for the Laplace LUT character stream. It issues one index request to the LUT stream source and captures the ASCII characters that come back into a local buffer. The source tags each character with a chars-remaining count; the reader uses that count to detect end-of-entry. The block sits between the control logic and the LUT transmitter, and the control logic reads the captured string out by address.

## Interface
Parameters:
- IDX_W, 4 — width of the LUT entry index.
- DEPTH, 32 — buffer depth in characters; power of two, ≥ 4.
- TIMEOUT, 255 — idle-cycle limit for the watchdog (only used with the Configuration macro); ≥ 2.

Ports:
- clk  in  1  — single clock; all logic on the rising edge.
- rst_n  in  1  — reset, asynchronous and active-low.
- start  in  1  — request a fetch; sampled only in IDLE.
- index  in  IDX_W  — entry to fetch; latched on accepted start.
- busy  out  1  — high in REQ and RECV.
- done  out  1  — one-cycle pulse when an entry completes.
- error  out  1  — sticky timeout flag; cleared by the next accepted start.
- overflow  out  1  — sticky; characters were dropped; cleared by the next accepted start.
- count  out  $clog2(DEPTH)+1  — number of characters stored.
- lut_req  out  1  — request to the source; held until acknowledged.
- lut_index  out  IDX_W  — latched index; valid while lut_req is high.
- lut_ack  in  1  — source accepted the request.
- char_valid  in  1  — char_data is valid this cycle.
- char_data  in  8  — ASCII character.
- chars_remaining  in  8  — characters still to follow this one; 0 marks the last character.
- rd_addr  in  $clog2(DEPTH)  — buffer read address.
- rd_data  out  8  — registered read data.

## Operation
The reader has four states: IDLE, REQ, RECV and DONE.

- **IDLE**
  - On start: latch index; clear count, error and overflow; go to REQ.
  - Without start: stay in IDLE.
- **REQ**
  - lut_req = 1.
  - On lut_ack: drop lut_req on the next edge and go to RECV.
  - char_valid is ignored in REQ.
- **RECV**
  - Each cycle with char_valid:
    - If count < DEPTH: write char_data to buffer[count] and increment count.
    - Otherwise: drop the character and set overflow.
  - char_valid with chars_remaining == 0 goes to DONE. That final character is stored under the same rule.
  - Gaps of any length between characters are legal.
- **DONE**
  - done = 1 for exactly one cycle, then go to IDLE.

General rules:
- start is ignored in REQ, RECV and DONE; it is not queued.
- Buffer contents and count persist after DONE until the next accepted start.
- The buffer is not cleared on reset; count is.
- The read port is independent of the state machine and usable at any time.
- A write and a read to the same address in the same cycle return the old data.

## Timing
- Reset value of every output is 0. rd_data is 0 until the first read edge after reset.
- Reset asserted mid-transfer aborts at once: the reader returns to IDLE and all outputs go to 0.
- start accepted at edge N → busy and lut_req are high after edge N.
- lut_ack sampled at edge M → lut_req is low after edge M.
- A character sampled at edge K → count is updated after edge K.
- Last character at edge K → done is high in the cycle after edge K, and busy is low in that same cycle.
- rd_data latency is 1 cycle from rd_addr.

## Configuration
- READER_TIMEOUT_EN defined:
  - A watchdog counter resets on every accepted start, lut_ack and char_valid, and increments each cycle in REQ and RECV.
  - When the counter reaches TIMEOUT: set error, drop lut_req, go to IDLE. done does not pulse.
  - Characters already captured remain readable and count is kept.
- READER_TIMEOUT_EN undefined:
  - No watchdog; REQ and RECV wait indefinitely.
  - error is tied to 0.

## Test plan
- **Basic fetch:** start with index=3; lut_ack 2 cycles later; stream "1/s^2" with chars_remaining 4,3,2,1,0 and one idle cycle between characters → count=5, done pulses once, rd_addr 0..4 reads 0x31,0x2F,0x73,0x5E,0x32, error=0, overflow=0.
- **Overflow:** DEPTH=4; stream 6 characters "ABCDEF" ending with chars_remaining=0 → count=4, buffer holds "ABCD", overflow=1, done pulses once.
- **Busy lockout:** pulse start with index=5 during RECV → lut_index stays 3, no second request is issued; a start after done is accepted.
- **Single character:** first character arrives with chars_remaining=0 → count=1, done asserts the cycle after that character.
- **Timeout (macro on, TIMEOUT=8):** start with no lut_ack → lut_req drops, error=1 after 8 cycles in REQ, done never pulses. The next start clears error.
- **Reset mid-RECV:** after 2 of 5 characters, pulse rst_n low → count, busy, lut_req, done, error and overflow all read 0 immediately; a subsequent start works normally.
